// File: rtl/dp_bram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its clear sequencer.
package dp_bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

  // Port B read-during-write behaviour
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/bram_clear_seq.sv
// Clear sweep sequencer: walks every word address once, then idles in RUN until clr.
module bram_clear_seq
  import dp_bram_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam clr_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  clr_state_t        r_state;
  clr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        // clr is deliberately ignored while a sweep is running
        if (r_cnt == LAST_ADDR) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        if (clr) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/dp_bram_be.sv
// Dual-port block RAM: port A read-only, port B read/write with big-endian byte lanes,
// self-clearing sweep, optional output pipeline register and selectable port B RDW mode.
module dp_bram_be
  import dp_bram_pkg::*;
#(
  parameter int                    DATA_BYTES     = 2,
  parameter int                    ADDR_W         = 9,
  parameter logic [8*DATA_BYTES-1:0] INIT_WORD    = 16'hF000,
  parameter int                    OUT_REG        = 0,
  parameter int                    B_RDW_MODE     = RDW_OLD,
  parameter int                    CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    a_en,
  input  logic [ADDR_W-1:0]       a_addr,
  output logic [8*DATA_BYTES-1:0] a_dout,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic [DATA_BYTES-1:0]   b_we,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [8*DATA_BYTES-1:0] b_din,
  output logic [8*DATA_BYTES-1:0] b_dout,
  output logic                    b_valid,
  output logic                    busy,
  output logic                    collision
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DW-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic [ADDR_W-1:0]     w_clr_addr;
  logic                  w_a_req;
  logic                  w_b_req;
  logic                  w_col;
  logic [DATA_BYTES-1:0] w_wr_be;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [DW-1:0]         w_wr_data;
  logic [DATA_BYTES-1:0] w_b_fwd;

  logic [DW-1:0] r_a_q;
  logic [DW-1:0] r_b_q;
  logic          r_a_v;
  logic          r_b_v;
  logic          r_col;

  bram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (w_busy),
    .clr_addr(w_clr_addr)
  );

  assign w_a_req = a_en & ~w_busy;
  assign w_b_req = b_en & ~w_busy;
  assign w_col   = w_a_req & w_b_req & (|b_we) & (a_addr == b_addr);

  // The sweep borrows the port B write path so the array keeps a single write port
  assign w_wr_be   = w_busy ? '1 : (w_b_req ? b_we : '0);
  assign w_wr_addr = w_busy ? w_clr_addr : b_addr;
  assign w_wr_data = w_busy ? INIT_WORD : b_din;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_fwd
      assign w_b_fwd[gi] = (B_RDW_MODE == RDW_NEW) && b_we[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (w_wr_be[i]) r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
    end
  end

  // Reads sample the array before this cycle's write lands, so port A sees old data on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q <= INIT_WORD;
      r_b_q <= '0;
      r_a_v <= 1'b0;
      r_b_v <= 1'b0;
      r_col <= 1'b0;
    end else begin
      r_a_v <= w_a_req;
      r_b_v <= w_b_req;
      r_col <= w_col;
      if (w_a_req) r_a_q <= r_mem[a_addr];
      if (w_b_req) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          r_b_q[8*i +: 8] <= w_b_fwd[i] ? b_din[8*i +: 8] : r_mem[b_addr][8*i +: 8];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_a_q2;
      logic [DW-1:0] r_b_q2;
      logic          r_a_v2;
      logic          r_b_v2;
      logic          r_col2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_q2 <= INIT_WORD;
          r_b_q2 <= '0;
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_col2 <= 1'b0;
        end else begin
          r_a_v2 <= r_a_v;
          r_b_v2 <= r_b_v;
          r_col2 <= r_col;
          if (r_a_v) r_a_q2 <= r_a_q;
          if (r_b_v) r_b_q2 <= r_b_q;
        end
      end

      assign a_dout    = r_a_q2;
      assign b_dout    = r_b_q2;
      assign a_valid   = r_a_v2;
      assign b_valid   = r_b_v2;
      assign collision = r_col2;
    end else begin : g_noreg
      assign a_dout    = r_a_q;
      assign b_dout    = r_b_q;
      assign a_valid   = r_a_v;
      assign b_valid   = r_b_v;
      assign collision = r_col;
    end
  endgenerate

  assign busy = w_busy;

endmodule

// File: tb/tb_dp_bram_be.sv
// Scoreboard bench for dp_bram_be: one default instance and one with OUT_REG=1 / new-data RDW,
// both driven by the same directed stimulus.
module tb_dp_bram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, a_en, b_en;
  logic [8:0]  a_addr, b_addr;
  logic [1:0]  b_we;
  logic [15:0] b_din;

  logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_valid0, b_valid0, a_valid1, b_valid1;
  logic        busy0, busy1, col0, col1;

  dp_bram_be u_dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .a_en(a_en), .a_addr(a_addr), .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout0), .b_valid(b_valid0), .busy(busy0), .collision(col0)
  );

  dp_bram_be #(.OUT_REG(1), .B_RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .a_en(a_en), .a_addr(a_addr), .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout1), .b_valid(b_valid1), .busy(busy1), .collision(col1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] d;
    logic        col;
    logic        has_col;
    int          due;
  } exp_t;

  exp_t qa0[$], qb0[$], qa1[$], qb1[$];

  task automatic chk(input string nm, input exp_t e, input logic [15:0] d, input logic col);
    n_tests++;
    if (d !== e.d || (e.has_col && col !== e.col) || cyc != e.due) begin
      n_fail++;
      $display("[TB] FAIL %s: got data=%h col=%b cyc=%0d, expected data=%h col=%b cyc=%0d",
               nm, d, col, cyc, e.d, e.col, e.due);
    end else begin
      $display("[TB] ok %s data=%h col=%b cyc=%0d", nm, d, col, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: unexpected pulse at cyc=%0d, expected none", nm, cyc);
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, got, exp);
    end else begin
      $display("[TB] ok %s = %h", nm, got);
    end
  endtask

  // Monitor: every valid pops the oldest expectation for its port
  always @(negedge clk) begin
    if (a_valid0) begin
      if (qa0.size() == 0) unexp("A0"); else chk("A0", qa0.pop_front(), a_dout0, col0);
    end
    if (b_valid0) begin
      if (qb0.size() == 0) unexp("B0"); else chk("B0", qb0.pop_front(), b_dout0, 1'b0);
    end
    if (a_valid1) begin
      if (qa1.size() == 0) unexp("A1"); else chk("A1", qa1.pop_front(), a_dout1, col1);
    end
    if (b_valid1) begin
      if (qb1.size() == 0) unexp("B1"); else chk("B1", qb1.pop_front(), b_dout1, 1'b0);
    end
    if (col0 && !a_valid0) unexp("COL0");
    if (col1 && !a_valid1) unexp("COL1");
  end

  // One request cycle; eb0/eb1 are the port B results for old-data and new-data RDW instances
  task automatic issue(input logic ae, input logic [8:0] aa, input logic [15:0] ea, input logic ec,
                       input logic be, input logic [1:0] bwe, input logic [8:0] ba,
                       input logic [15:0] bd, input logic [15:0] eb0, input logic [15:0] eb1);
    exp_t e;
    a_en = ae; a_addr = aa; b_en = be; b_we = bwe; b_addr = ba; b_din = bd;
    if (ae) begin
      e = '{ea, ec, 1'b1, cyc + 1}; qa0.push_back(e);
      e = '{ea, ec, 1'b1, cyc + 2}; qa1.push_back(e);
    end
    if (be) begin
      e = '{eb0, 1'b0, 1'b0, cyc + 1}; qb0.push_back(e);
      e = '{eb1, 1'b0, 1'b0, cyc + 2}; qb1.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    a_en = 1'b0; b_en = 1'b0; b_we = 2'b00; clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int clr_at, output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      clr = (i == clr_at);
      if (busy0) n0++;
      if (busy1) n1++;
      if (!busy0 && !busy1) begin
        a_en = 1'b0; b_en = 1'b0; b_we = 2'b00; clr = 1'b0;
        break;
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, " a_dout0"}, 32'(a_dout0), 32'h0000F000);
    check_val({tag, " b_dout0"}, 32'(b_dout0), 32'h0);
    check_val({tag, " a_dout1"}, 32'(a_dout1), 32'h0000F000);
    check_val({tag, " b_dout1"}, 32'(b_dout1), 32'h0);
    check_val({tag, " valids/col0"}, {29'd0, a_valid0, b_valid0, col0}, 32'h0);
    check_val({tag, " valids/col1"}, {29'd0, a_valid1, b_valid1, col1}, 32'h0);
    check_val({tag, " busy"}, {30'd0, busy0, busy1}, 32'h3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  int n0, n1;

  initial begin
    rst = 1'b0; clr = 1'b0; a_en = 1'b0; b_en = 1'b0; b_we = 2'b00;
    a_addr = '0; b_addr = '0; b_din = '0;
    #1 rst = 1'b1;
    #2 reset_checks("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Requests during the sweep must be ignored
    a_en = 1'b1; a_addr = 9'd3; b_en = 1'b1; b_we = 2'b11; b_addr = 9'd3; b_din = 16'hDEAD;
    count_busy(-1, n0, n1);
    check_val("sweep0 busy cycles dut0", 32'(n0), 32'd512);
    check_val("sweep0 busy cycles dut1", 32'(n1), 32'd512);
    @(posedge clk); #1;

    for (int a = 0; a < 512; a++)
      issue(1'b1, 9'(a), 16'hF000, 1'b0, 1'b1, 2'b00, 9'(511 - a), 16'h0, 16'hF000, 16'hF000);

    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b11, 9'd5, 16'h1234, 16'hF000, 16'h1234);
    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b10, 9'd5, 16'hABCD, 16'h1234, 16'hAB34);
    issue(1'b1, 9'd5, 16'hAB34, 1'b0, 1'b0, 2'b00, 9'd0, 16'h0, 16'h0, 16'h0);
    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b11, 9'd6, 16'h0000, 16'hF000, 16'h0000);
    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b01, 9'd6, 16'h5566, 16'h0000, 16'h0066);
    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b00, 9'd6, 16'h0, 16'h0066, 16'h0066);
    issue(1'b0, 9'd0, 16'h0, 1'b0, 1'b1, 2'b11, 9'd7, 16'h1111, 16'hF000, 16'h1111);
    issue(1'b1, 9'd7, 16'h1111, 1'b1, 1'b1, 2'b11, 9'd7, 16'h2222, 16'h1111, 16'h2222);
    issue(1'b1, 9'd7, 16'h2222, 1'b0, 1'b0, 2'b00, 9'd0, 16'h0, 16'h0, 16'h0);
    idle(2);

    issue(1'b1, 9'd5, 16'hAB34, 1'b0, 1'b1, 2'b00, 9'd7, 16'h0, 16'h2222, 16'h2222);
    issue(1'b1, 9'd6, 16'h0066, 1'b0, 1'b1, 2'b00, 9'd6, 16'h0, 16'h0066, 16'h0066);
    issue(1'b1, 9'd7, 16'h2222, 1'b0, 1'b1, 2'b00, 9'd5, 16'h0, 16'hAB34, 16'hAB34);
    issue(1'b1, 9'd5, 16'hAB34, 1'b0, 1'b1, 2'b00, 9'd7, 16'h0, 16'h2222, 16'h2222);
    idle(4);

    // Leave non-reset values on the outputs, then reset part-way through a sweep
    issue(1'b1, 9'd5, 16'hAB34, 1'b0, 1'b1, 2'b00, 9'd6, 16'h0, 16'h0066, 16'h0066);
    idle(4);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("rst mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    count_busy(-1, n0, n1);
    check_val("sweep1 busy cycles dut0", 32'(n0), 32'd512);
    check_val("sweep1 busy cycles dut1", 32'(n1), 32'd512);
    @(posedge clk); #1;

    // clr in RUN starts a sweep; a second clr mid-sweep is ignored
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(50, n0, n1);
    check_val("sweep2 busy cycles dut0", 32'(n0), 32'd512);
    check_val("sweep2 busy cycles dut1", 32'(n1), 32'd512);
    @(posedge clk); #1;

    issue(1'b1, 9'd5, 16'hF000, 1'b0, 1'b1, 2'b00, 9'd7, 16'h0, 16'hF000, 16'hF000);
    issue(1'b1, 9'd6, 16'hF000, 1'b0, 1'b0, 2'b00, 9'd0, 16'h0, 16'h0, 16'h0);
    idle(5);

    check_val("pending expectations", 32'(qa0.size() + qb0.size() + qa1.size() + qb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_bram_be.md
DP_BRAM_BE -- requirements
Module: dp_bram_be

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: bytes per word.
REQ-002 SHALL have parameter ADDR_W, default 9: word-address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter INIT_WORD, default 16'hF000 (NOP), width 8*DATA_BYTES: clear value.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds an output pipeline register on both ports.
REQ-005 SHALL have parameter B_RDW_MODE, default 0: port B read-during-write returns old data (0) or new data (1).
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1: 1 runs the clear sweep after reset.
REQ-007 SHALL have ports, one per line:
clk  in  1  clock;
rst  in  1  reset, asynchronous, active-high;
clr  in  1  start clear sweep (pulse);
a_en  in  1  port A read enable;
a_addr  in  ADDR_W  port A word address;
a_dout  out  8*DATA_BYTES  port A read data;
a_valid  out  1  a_dout holds new data;
b_en  in  1  port B access enable;
b_we  in  DATA_BYTES  per-byte write enables;
b_addr  in  ADDR_W  port B word address;
b_din  in  8*DATA_BYTES  port B write data;
b_dout  out  8*DATA_BYTES  port B read data;
b_valid  out  1  b_dout holds new data;
busy  out  1  clear sweep in progress;
collision  out  1  A/B same-address write conflict flag.

Function
REQ-008 Byte order SHALL be big-endian: lane i (bits 8i+7:8i) sits at byte address word*DATA_BYTES + (DATA_BYTES-1-i); b_we[i] gates lane i only.
REQ-009 The FSM SHALL have two states: CLEAR and RUN.
REQ-010 In CLEAR, one word per cycle SHALL be written with INIT_WORD at counter address, starting at 0; after word DEPTH-1 the next state SHALL be RUN; busy = (state==CLEAR).
REQ-011 In RUN, a clr pulse SHALL enter CLEAR with counter 0; clr in CLEAR SHALL be ignored.
REQ-012 In CLEAR, a_en and b_en SHALL be ignored: no writes, valids stay 0, douts hold.
REQ-013 In RUN, a_en/b_en SHALL produce read data at latency 1+OUT_REG cycles with the matching valid high for exactly one cycle per request.
REQ-014 Back-to-back requests SHALL be accepted every cycle (full throughput).
REQ-015 Without a new request, dout SHALL hold its last value and valid SHALL be 0.
REQ-016 On a port B write, b_dout SHALL return pre-write data if B_RDW_MODE=0, or the merged post-write word if 1.
REQ-017 When a_en, b_en, |b_we and a_addr==b_addr in the same RUN cycle, port A SHALL return pre-write data and collision SHALL pulse high, aligned with that a_valid.
REQ-018 Addresses SHALL be used modulo DEPTH, no out-of-range error.

Reset
REQ-019 Asserting rst SHALL immediately force: a_dout=INIT_WORD, b_dout=0, a_valid=0, b_valid=0, collision=0, pipeline registers cleared.
REQ-020 Asserting rst SHALL set state to CLEAR (CLEAR_ON_RESET=1) or RUN (0), with counter 0.
REQ-021 Memory contents SHALL NOT be reset; rst during CLEAR SHALL restart the sweep from 0.

Structure
REQ-022 Package dp_bram_pkg SHALL hold the state enum and the B_RDW_MODE constants RDW_OLD=0 and RDW_NEW=1.
REQ-023 The clear FSM and counter SHALL be a sub-module bram_clear_seq; the array SHALL remain block-RAM inferable.

Verification
REQ-024 Reset, CLEAR_ON_RESET=1, DEPTH=512 -> busy high exactly 512 cycles; then every address reads 16'hF000.
REQ-025 RUN, b_we=2'b10, b_din=16'hABCD to addr 5 over 16'h1234 -> read addr 5 returns 16'hAB34 (lane 1 = byte address 10).
REQ-026 Same cycle: A reads addr 7 (holds 16'h1111), B writes 16'h2222 to addr 7 -> a_dout=16'h1111, collision=1 for one cycle; b_dout=16'h1111 (RDW_OLD) or 16'h2222 (RDW_NEW).
REQ-027 OUT_REG=1, reads on 4 consecutive cycles -> 4 valid pulses, each 2 cycles after its request, data in order.
REQ-028 rst asserted at sweep word 100 -> outputs cleared immediately; sweep restarts at 0; busy lasts 512 cycles after release.
